// File: rtl/mdu_if.sv
// mdu_if: E-stage request, HI/LO read-back and busy status between the pipeline and the MDU
interface mdu_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mf_sel;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] md_out;
    modport master (output start, md_op, A, B, mf_sel, input busy, HI, LO, md_out);
    modport slave  (input start, md_op, A, B, mf_sel, output busy, HI, LO, md_out);
endinterface

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the architectural HI/LO registers
module mdu #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input logic   clk,
    input logic   reset,
    mdu_if.slave  bus
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);
    localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                           OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6;

    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_wr;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [63:0]   r_pend;

    logic          w_sdiv;
    logic [31:0]   w_ma, w_mb, w_dv, w_q, w_r, w_quo, w_rem;
    logic [63:0]   w_prod_s, w_prod_u;

    assign w_prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    assign w_prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    // signed divide on magnitudes, so 0x80000000 / -1 wraps to 0x80000000 with remainder 0
    assign w_sdiv = (bus.md_op == OP_DIV);
    assign w_ma   = (w_sdiv && bus.A[31]) ? -bus.A : bus.A;
    assign w_mb   = (w_sdiv && bus.B[31]) ? -bus.B : bus.B;
    assign w_dv   = (w_mb == 32'd0) ? 32'd1 : w_mb;
    assign w_q    = w_ma / w_dv;
    assign w_r    = w_ma % w_dv;
    assign w_quo  = (w_sdiv && (bus.A[31] ^ bus.B[31])) ? -w_q : w_q;
    assign w_rem  = (w_sdiv && bus.A[31]) ? -w_r : w_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_wr   <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_pend <= '0;
        end else if (r_busy) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) begin
                r_busy <= 1'b0;
                if (r_wr) {r_hi, r_lo} <= r_pend;
            end
        end else if (bus.start) begin
            case (bus.md_op)
                OP_MULT, OP_MULTU: begin
                    r_pend <= (bus.md_op == OP_MULT) ? w_prod_s : w_prod_u;
                    r_wr   <= 1'b1;
                    r_cnt  <= CW'(MULT_LAT);
                    r_busy <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    r_pend <= {w_rem, w_quo};
                    r_wr   <= |bus.B;
                    r_cnt  <= CW'(DIV_LAT);
                    r_busy <= 1'b1;
                end
                OP_MTHI: r_hi <= bus.A;
                OP_MTLO: r_lo <= bus.A;
                default: ;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.HI     = r_hi;
    assign bus.LO     = r_lo;
    assign bus.md_out = bus.mf_sel ? r_hi : r_lo;
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: vector table through an expected-result queue, plus reset and busy-overlap sequences
module tb_mdu;
    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    vec_t sb[$];
    vec_t tbl[16];

    always #5 clk = ~clk;

    mdu_if bus ();
    mdu #(.MULT_LAT(5), .DIV_LAT(10)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic issue(input vec_t v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.md_op = v.op;
        bus.A     = v.a;
        bus.B     = v.b;
        sb.push_back(v);
        @(negedge clk);
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    task automatic finish_op(input string name);
        vec_t e;
        int   n = 0;
        while (bus.busy === 1'b1 && n < 100) begin
            chk({name, " hold HI"}, bus.HI, m_hi);
            chk({name, " hold LO"}, bus.LO, m_lo);
            bus.A = $urandom;
            bus.B = $urandom;
            n++;
            @(negedge clk);
        end
        e = sb.pop_front();
        chk({name, " busy cycles"}, 32'(n), 32'(e.lat));
        chk({name, " HI"}, bus.HI, e.hi);
        chk({name, " LO"}, bus.LO, e.lo);
        bus.mf_sel = 1'b1;
        #1 chk({name, " md_out HI"}, bus.md_out, e.hi);
        bus.mf_sel = 1'b0;
        #1 chk({name, " md_out LO"}, bus.md_out, e.lo);
        m_hi = e.hi;
        m_lo = e.lo;
    endtask

    initial begin
        tbl[0]  = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        tbl[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        tbl[2]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tbl[3]  = '{3'd4, 32'd7,        32'd2,        32'd1,        32'd3,        10};
        tbl[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10};
        tbl[5]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
        tbl[6]  = '{3'd4, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 10};
        tbl[7]  = '{3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
        tbl[8]  = '{3'd5, 32'h11,       32'd0,        32'h11,       32'h00000001, 0};
        tbl[9]  = '{3'd6, 32'h22,       32'd0,        32'h11,       32'h22,       0};
        tbl[10] = '{3'd3, 32'd5,        32'd0,        32'h11,       32'h22,       10};
        tbl[11] = '{3'd4, 32'd5,        32'd0,        32'h11,       32'h22,       10};
        tbl[12] = '{3'd5, 32'hABCD,     32'd0,        32'hABCD,     32'h22,       0};
        tbl[13] = '{3'd0, 32'h1234,     32'h5678,     32'hABCD,     32'h22,       0};
        tbl[14] = '{3'd7, 32'h1234,     32'h5678,     32'hABCD,     32'h22,       0};
        tbl[15] = '{3'd2, 32'd0,        32'hFFFFFFFF, 32'd0,        32'd0,        5};

        bus.start = 1'b1;
        bus.md_op = 3'd1;
        bus.A = 32'd3;
        bus.B = 32'd4;
        bus.mf_sel = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset HI", bus.HI, 32'd0);
        chk("reset LO", bus.LO, 32'd0);
        chk("reset md_out", bus.md_out, 32'd0);
        reset = 1'b0;
        bus.start = 1'b0;
        bus.md_op = 3'd0;

        foreach (tbl[i]) begin
            issue(tbl[i]);
            finish_op($sformatf("vec%0d", i));
        end

        // MTLO held on start during a MULT is ignored until the first idle edge
        issue('{3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5});
        bus.start = 1'b1;
        bus.md_op = 3'd6;
        bus.A = 32'h55;
        begin
            vec_t e;
            int   n = 0;
            while (bus.busy === 1'b1 && n < 100) begin
                chk("overlap hold LO", bus.LO, m_lo);
                n++;
                @(negedge clk);
            end
            e = sb.pop_front();
            chk("overlap busy cycles", 32'(n), 32'(e.lat));
            chk("overlap LO product", bus.LO, e.lo);
            chk("overlap HI product", bus.HI, e.hi);
            @(negedge clk);
            bus.start = 1'b0;
            bus.md_op = 3'd0;
            chk("overlap MTLO accepted", bus.LO, 32'h55);
            chk("overlap MTLO no busy", 32'(bus.busy), 32'd0);
            m_hi = 32'd0;
            m_lo = 32'h55;
        end

        // reset during a DIV discards the pending result
        issue('{3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10});
        void'(sb.pop_front());
        repeat (2) @(negedge clk);
        chk("pre-reset busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid reset busy", 32'(bus.busy), 32'd0);
        chk("mid reset HI", bus.HI, 32'd0);
        chk("mid reset LO", bus.LO, 32'd0);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("no late HI", bus.HI, 32'd0);
            chk("no late LO", bus.LO, 32'd0);
        end

        // reset wins over a start on the same edge
        bus.start = 1'b1;
        bus.md_op = 3'd5;
        bus.A = 32'hDEAD;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        chk("reset prio HI", bus.HI, 32'd0);
        chk("reset prio busy", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
